// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift ops with a registered result,
// plus an iterative signed shift-add multiplier that writes HI/LO and stalls the pipeline.
module alu_exec_unit #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MUL_CYCLES) + 1;

  localparam logic [5:0] OP_ADD  = 6'b010000;
  localparam logic [5:0] OP_SUB  = 6'b010001;
  localparam logic [5:0] OP_AND  = 6'b010010;
  localparam logic [5:0] OP_OR   = 6'b010011;
  localparam logic [5:0] OP_XOR  = 6'b010101;
  localparam logic [5:0] OP_SLL  = 6'b110000;
  localparam logic [5:0] OP_SRL  = 6'b110001;
  localparam logic [5:0] OP_SLT  = 6'b110011;
  localparam logic [5:0] OP_MULT = 6'b010110;

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     alu_res;
  logic [CW-1:0]        count;
  logic                 sign;
  logic                 accept;
  logic                 is_mult;

  assign busy     = (state != IDLE);
  assign in_ready = ~busy;
  assign accept   = in_valid & in_ready;
  assign is_mult  = (alu_control == OP_MULT);

  // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1)
  assign a_mag   = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
  assign b_mag   = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
  assign product = sign ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;

  always_comb begin
    alu_res = a + b;
    case (alu_control)
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLL: alu_res = a << b[3:0];
      OP_SRL: alu_res = a >> b[3:0];
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = a + b;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mult) state_next = MUL;
      MUL:  if (count == CW'(MUL_CYCLES - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Multiplicand shifts left and multiplier shifts right, one partial product per edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      sign      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mult) begin
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              acc    <= '0;
              count  <= '0;
              sign   <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        FIX: begin
          hi        <= product[2*WIDTH-1:WIDTH];
          lo        <= product[WIDTH-1:0];
          result    <= product[WIDTH-1:0];
          zero      <= (product[WIDTH-1:0] == '0);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random ops,
// compared against an integer-arithmetic reference model.
module tb_alu_exec_unit;

  localparam logic [5:0] OP_ADD  = 6'b010000;
  localparam logic [5:0] OP_SUB  = 6'b010001;
  localparam logic [5:0] OP_AND  = 6'b010010;
  localparam logic [5:0] OP_OR   = 6'b010011;
  localparam logic [5:0] OP_XOR  = 6'b010101;
  localparam logic [5:0] OP_SLL  = 6'b110000;
  localparam logic [5:0] OP_SRL  = 6'b110001;
  localparam logic [5:0] OP_SLT  = 6'b110011;
  localparam logic [5:0] OP_MULT = 6'b010110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  alu_control;
  logic [15:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic        zero;
  logic        out_valid;
  logic        busy;
  logic [15:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_hi = 16'h0;
  logic [15:0] exp_lo = 16'h0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(16), .MUL_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .alu_control(alu_control), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero),
    .out_valid(out_valid), .busy(busy), .hi(hi), .lo(lo)
  );

  // Reference: plain integer arithmetic, truncated to 16 bits (32 bits for mult)
  function automatic logic [31:0] refModel(logic [5:0] code, logic [15:0] x, logic [15:0] y);
    int ux, uy, sx, sy, t;
    logic [15:0] sx16, sy16;
    ux = int'(x);
    uy = int'(y);
    sx16 = x;
    sy16 = y;
    sx = $signed(sx16);
    sy = $signed(sy16);
    case (code)
      OP_SUB:  t = ux - uy;
      OP_AND:  t = ux & uy;
      OP_OR:   t = ux | uy;
      OP_XOR:  t = ux ^ uy;
      OP_SLL:  t = ux * (1 << (uy % 16));
      OP_SRL:  t = ux / (1 << (uy % 16));
      OP_SLT:  t = (sx < sy) ? 1 : 0;
      OP_MULT: return 32'(sx * sy);
      default: t = ux + uy;
    endcase
    return {16'h0, t[15:0]};
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the posedge+1 after the accept edge
  task automatic applyStimulus(logic [5:0] code, logic [15:0] x, logic [15:0] y);
    alu_control = code;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic runSingle(string tag, logic [5:0] code, logic [15:0] x, logic [15:0] y);
    logic [31:0] r;
    r = refModel(code, x, y);
    applyStimulus(code, x, y);
    @(negedge clk);
    checkOutput({tag, ".out_valid"}, {31'h0, out_valid}, 32'h1);
    checkOutput({tag, ".result"}, {16'h0, result}, r);
    checkOutput({tag, ".zero"}, {31'h0, zero}, {31'h0, (r == 32'h0)});
    checkOutput({tag, ".busy"}, {31'h0, busy}, 32'h0);
    checkOutput({tag, ".hilo"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  task automatic runMult(string tag, logic [15:0] x, logic [15:0] y, logic poke);
    logic [31:0] p;
    int cycles;
    int strays;
    p = refModel(OP_MULT, x, y);
    cycles = 0;
    strays = 0;
    applyStimulus(OP_MULT, x, y);
    @(negedge clk);
    checkOutput({tag, ".in_ready_busy"}, {31'h0, in_ready}, 32'h0);
    while (busy && cycles < 40) begin
      if (out_valid) strays++;
      if (poke) begin
        alu_control = OP_ADD;
        a = 16'h1111;
        b = 16'h2222;
        in_valid = 1'b1;
      end
      cycles++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    exp_hi = p[31:16];
    exp_lo = p[15:0];
    checkOutput({tag, ".busy_cycles"}, 32'(cycles), 32'd17);
    checkOutput({tag, ".strays"}, 32'(strays), 32'd0);
    checkOutput({tag, ".out_valid"}, {31'h0, out_valid}, 32'h1);
    checkOutput({tag, ".hilo"}, {hi, lo}, p);
    checkOutput({tag, ".result"}, {16'h0, result}, {16'h0, p[15:0]});
    checkOutput({tag, ".zero"}, {31'h0, zero}, {31'h0, (p[15:0] == 16'h0)});
  endtask

  initial begin
    logic [5:0]  code;
    logic [15:0] x, y;

    rst_n = 1'b0;
    in_valid = 1'b0;
    alu_control = 6'h0;
    a = 16'h0;
    b = 16'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset.outs", {result, 14'h0, zero, out_valid}, 32'h0);
    checkOutput("reset.hilo", {hi, lo}, 32'h0);
    checkOutput("reset.busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset.in_ready", {31'h0, in_ready}, 32'h1);

    runSingle("add_ovf", OP_ADD, 16'h7FFF, 16'h0001);
    @(negedge clk);
    checkOutput("add_ovf.pulse_end", {31'h0, out_valid}, 32'h0);
    runSingle("sub_eq", OP_SUB, 16'h0005, 16'h0005);
    runSingle("unknown", 6'b111111, 16'h0002, 16'h0003);
    runSingle("sll", OP_SLL, 16'h0001, 16'h0004);
    runSingle("srl", OP_SRL, 16'h8000, 16'h000F);
    runSingle("slt_neg", OP_SLT, 16'hFFFF, 16'h0001);
    runSingle("slt_pos", OP_SLT, 16'h0001, 16'hFFFF);
    runSingle("and", OP_AND, 16'hF0F0, 16'h3C3C);
    runSingle("or", OP_OR, 16'hF0F0, 16'h0F0F);
    runSingle("xor", OP_XOR, 16'hAAAA, 16'hAAAA);

    @(negedge clk);
    runMult("mult_neg", 16'hFFFD, 16'h0007, 1'b1);
    @(negedge clk);
    checkOutput("mult_neg.no_late_accept", {31'h0, out_valid}, 32'h0);

    runMult("mult_min", 16'h8000, 16'h8000, 1'b0);
    runSingle("b2b_add", OP_ADD, 16'h1234, 16'h1111);

    for (int i = 0; i < 40; i++) begin
      code = 6'($urandom_range(0, 63));
      if (code == OP_MULT) code = OP_SLT;
      if (i % 3 == 0) code = (i % 2 == 0) ? OP_SLL : OP_SUB;
      x = 16'($urandom);
      y = 16'($urandom);
      runSingle("rand_op", code, x, y);
    end

    for (int i = 0; i < 6; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i == 0) y = 16'h0000;
      if (i == 1) x = 16'hFFFF;
      @(negedge clk);
      runMult("rand_mult", x, y, 1'(i % 2));
    end

    @(negedge clk);
    applyStimulus(OP_MULT, 16'h1234, 16'hF00D);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_hi = 16'h0;
    exp_lo = 16'h0;
    checkOutput("midreset.busy", {31'h0, busy}, 32'h0);
    checkOutput("midreset.hilo", {hi, lo}, 32'h0);
    checkOutput("midreset.result", {15'h0, zero, result}, 32'h0);
    checkOutput("midreset.out_valid", {31'h0, out_valid}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("midreset.quiet", {30'h0, busy, out_valid}, 32'h0);
    end
    runSingle("post_reset_add", OP_ADD, 16'h0001, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
